// File: rtl/spi_slave.sv
// SPI slave byte transceiver, oversampled by the local clock.
// All four CPOL/CPHA modes, MSB- or LSB-first, 8-bit words.
module spi_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       msb_first,
    input  logic [7:0] data_out,
    output logic [7:0] data_in,
    output logic       busy,
    output logic       end_of_byte
);

    typedef enum logic [0:0] {
        IDLE,
        ACTIVE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       sck_meta;
    logic       sck_sync;
    logic       sck_prev;
    logic       cs_meta;
    logic       cs_sync;
    logic       cs_prev;
    logic       mosi_meta;
    logic       mosi_sync;

    logic       pol_q;
    logic       pha_q;
    logic       msbf_q;

    logic [2:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;

    logic       cs_fall;
    logic       cs_rise;
    logic       sck_rise;
    logic       sck_fall;
    logic       lead_edge;
    logic       trail_edge;
    logic       sample_edge;
    logic       change_edge;
    logic       select;
    logic       deselect;
    logic       last_bit;
    logic [7:0] rx_next;

    // Present a byte so that the bit to be sent first sits in bit 7.
    function automatic logic [7:0] tx_order(input logic [7:0] v,
                                            input logic       msbf);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return msbf ? v : r;
    endfunction

    // Two-flop synchronisers plus the previous-value edge registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // Edge classification against the mode captured at selection.
    always_comb begin
        cs_fall     = cs_prev & ~cs_sync;
        cs_rise     = ~cs_prev & cs_sync;
        sck_rise    = sck_sync & ~sck_prev;
        sck_fall    = ~sck_sync & sck_prev;
        lead_edge   = pol_q ? sck_fall : sck_rise;
        trail_edge  = pol_q ? sck_rise : sck_fall;
        sample_edge = 1'b0;
        change_edge = 1'b0;
        if (state == ACTIVE && !cs_rise) begin
            sample_edge = pha_q ? trail_edge : lead_edge;
            change_edge = pha_q ? lead_edge : trail_edge;
        end
        last_bit = sample_edge && (bit_cnt == 3'd7);
        rx_next  = msbf_q ? {rx_sr[6:0], mosi_sync}
                          : {mosi_sync, rx_sr[7:1]};
    end

    // Selection state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Selection next-state and select/deselect strobes.
    always_comb begin
        state_next = state;
        select     = 1'b0;
        deselect   = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    select     = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                busy = 1'b1;
                if (cs_rise) begin
                    deselect   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit counter, receive path and byte-complete strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= 3'd0;
            rx_sr       <= 8'h00;
            data_in     <= 8'h00;
            end_of_byte <= 1'b0;
            pol_q       <= 1'b0;
            pha_q       <= 1'b0;
            msbf_q      <= 1'b1;
        end else begin
            end_of_byte <= 1'b0;
            if (select) begin
                bit_cnt <= 3'd0;
                rx_sr   <= 8'h00;
                pol_q   <= cpol;
                pha_q   <= cpha;
                msbf_q  <= msb_first;
            end else if (deselect) begin
                bit_cnt <= 3'd0;
            end else if (sample_edge) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + 3'd1;
                if (last_bit) begin
                    data_in     <= rx_next;
                    end_of_byte <= 1'b1;
                end
            end
        end
    end

    // Transmit shifter: load on selection, shift or reload per mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr <= 8'h00;
        end else if (select) begin
            tx_sr <= tx_order(data_out, msb_first);
        end else if (pha_q) begin
            if (last_bit) begin
                tx_sr <= tx_order(data_out, msbf_q);
            end else if (change_edge && bit_cnt != 3'd0) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end else if (change_edge) begin
            if (bit_cnt == 3'd0) begin
                tx_sr <= tx_order(data_out, msbf_q);
            end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end

    assign miso = (busy && !rst) ? tx_sr[7] : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// Randomised scoreboard bench for spi_slave with a bit-level
// SPI master model driving all modes and byte orders.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs;
    logic       mosi;
    wire        miso;
    logic       cpol;
    logic       cpha;
    logic       msb_first;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic       busy;
    logic       end_of_byte;

    int         n_checks = 0;
    int         n_fail = 0;
    int         eob_cnt = 0;
    int         exp_bytes = 0;
    logic [7:0] last_din = 8'h00;
    logic [7:0] sb[$];
    logic [7:0] m_tx[4];
    logic [7:0] m_rx[4];

    spi_slave dut (
        .clk         (clk),
        .rst         (rst),
        .sck         (sck),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .cpol        (cpol),
        .cpha        (cpha),
        .msb_first   (msb_first),
        .data_out    (data_out),
        .data_in     (data_in),
        .busy        (busy),
        .end_of_byte (end_of_byte)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every byte strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && end_of_byte) begin
            eob_cnt++;
            check("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                check("data_in", data_in, sb.pop_front());
            end
        end
    end

    // SPI master: nbits bits over m_tx/m_rx, optional reset mid-transfer.
    task automatic xfer(input bit pol, input bit pha, input bit msbf,
                        input int nbits, input bit do_rst);
        logic [7:0] got;
        int         nfull;
        int         t0;
        int         d;
        int         k;
        got   = 8'h00;
        nfull = nbits / 8;
        for (int i = 0; i < nfull; i++) begin
            sb.push_back(m_rx[i]);
            exp_bytes++;
        end
        if (nfull > 0) last_din = m_rx[nfull-1];
        cpol      = pol;
        cpha      = pha;
        msb_first = msbf;
        sck       = pol;
        mosi      = 1'b0;
        data_out  = m_tx[0];
        #(2*HALF);
        cs = 1'b0;
        #(2*HALF);
        check("busy_selected", busy, 1);
        for (int b = 0; b < nbits; b++) begin
            int by;
            int ix;
            int bp;
            by = b / 8;
            ix = b % 8;
            bp = msbf ? 7 - ix : ix;
            if (!pha) begin
                mosi = m_rx[by][bp];
                #(HALF);
                sck     = ~pol;
                got[bp] = miso;
                t0      = int'($time);
                if (ix == 7) begin
                    k = 0;
                    while (!end_of_byte && k < 5) begin
                        @(negedge clk);
                        k++;
                    end
                    check("eob_in_time", end_of_byte, 1);
                    data_out = m_tx[(by+1)%4];
                end
                d = HALF - (int'($time) - t0);
                if (d > 0) #(d);
                sck = pol;
            end else begin
                #(HALF);
                sck  = ~pol;
                mosi = m_rx[by][bp];
                if (ix == 7) data_out = m_tx[(by+1)%4];
                #(HALF);
                sck     = pol;
                got[bp] = miso;
            end
            if (ix == 7) check("miso_byte", got, m_tx[by]);
        end
        #(HALF);
        if (do_rst) begin
            rst = 1'b1;
            #1;
            check("rst_busy", busy, 0);
            check("rst_data_in", data_in, 0);
            check("rst_eob", end_of_byte, 0);
            last_din = 8'h00;
            #(HALF);
            rst = 1'b0;
            #(2*HALF);
        end
        cs   = 1'b1;
        mosi = 1'b0;
        #(2*HALF);
        check("busy_released", busy, 0);
        check("eob_count", eob_cnt, exp_bytes);
        check("sb_drained", sb.size(), 0);
        check("data_in_hold", data_in, last_din);
    endtask

    initial begin
        rst       = 1'b1;
        cs        = 1'b1;
        sck       = 1'b0;
        mosi      = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        msb_first = 1'b1;
        data_out  = 8'h00;
        #55;
        check("reset_busy", busy, 0);
        check("reset_data_in", data_in, 0);
        check("reset_eob", end_of_byte, 0);
        rst = 1'b0;
        #(2*HALF);

        m_tx = '{8'h95, 8'h00, 8'h00, 8'h00};
        m_rx = '{8'h6B, 8'h00, 8'h00, 8'h00};
        xfer(0, 0, 1, 8, 0);

        m_rx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        xfer(0, 0, 0, 8, 0);

        m_tx = '{8'h3C, 8'h00, 8'h00, 8'h00};
        m_rx = '{8'hC3, 8'h00, 8'h00, 8'h00};
        xfer(1, 1, 1, 8, 0);

        m_tx = '{8'h95, 8'h5A, 8'h00, 8'h00};
        m_rx = '{8'h12, 8'h34, 8'h00, 8'h00};
        xfer(0, 0, 1, 16, 0);

        m_rx = '{8'hF0, 8'h00, 8'h00, 8'h00};
        xfer(0, 0, 1, 5, 0);
        m_rx = '{8'h81, 8'h00, 8'h00, 8'h00};
        xfer(0, 0, 1, 8, 0);

        m_tx = '{8'h95, 8'h00, 8'h00, 8'h00};
        xfer(0, 0, 1, 4, 1);
        m_rx = '{8'h6B, 8'h00, 8'h00, 8'h00};
        xfer(0, 0, 1, 8, 0);

        for (int t = 0; t < 24; t++) begin
            int nb;
            for (int i = 0; i < 4; i++) begin
                m_tx[i] = 8'($urandom);
                m_rx[i] = 8'($urandom);
            end
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31))
                                             : 8 * int'($urandom_range(1, 3));
            xfer(1'($urandom), 1'($urandom), 1'($urandom), nb,
                 $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
